// File: rtl/l3_arb_pkg.sv
// Shared types for the L3 port arbiter: FSM state encoding and latched operation kind.
package l3_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    localparam int WP = W + 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [WP-1:0]  sum;

    // Rotate the request vector so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl       = {req, req};
        rot       = N'(dbl >> ptr);
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && rot[k]) begin
                gnt_valid = 1'b1;
                sum       = {1'b0, ptr} + WP'(k);
                if (sum >= WP'(N)) begin
                    sum = sum - WP'(N);
                end
                gnt_idx = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/l3_port_arbiter.sv
// Shares the single AXI-lite single-beat L3 slave port between NUM_REQ L2 requesters.
// Round-robin grant, one transaction in flight, request captured at grant and replayed to L3,
// response steered back to the granted requester only.
module l3_port_arbiter
    import l3_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    // requester side
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_REQ-1:0]            s_awvalid,
    output logic [NUM_REQ-1:0]            s_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    output logic [NUM_REQ-1:0]            s_wready,
    output logic [NUM_REQ-1:0]            s_bvalid,
    input  logic [NUM_REQ-1:0]            s_bready,
    // L3 side
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    // status
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id
);

    arb_state_t              state_q, state_d;
    arb_op_t                 op_q, op_d;
    logic [IDX_W-1:0]        g_q, g_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0]      req;
    logic                    arb_vld;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        next_ptr;
    logic                    resp_hs;
    int                      gi;

    // A write only counts as a request once both its address and data are offered.
    assign req = s_arvalid | (s_awvalid & s_wvalid);

    rr_arbiter #(.N(NUM_REQ), .W(IDX_W)) u_rr (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_vld),
        .gnt_idx   (arb_idx)
    );

    assign next_ptr = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    assign m_araddr = addr_q;
    assign m_awaddr = addr_q;
    assign m_wdata  = wdata_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = g_q;

    // Response handshake for whichever operation is in flight, seen from the granted requester.
    assign resp_hs = (op_q == OP_RD) ? (m_rvalid & s_rready[g_q]) : (m_bvalid & s_bready[g_q]);

    // Next-state, capture and handshake steering; grant is suppressed while reset is held.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        s_arready = '0;
        s_awready = '0;
        s_wready  = '0;
        s_rvalid  = '0;
        s_bvalid  = '0;
        s_rdata   = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        gi        = int'(arb_idx);

        case (state_q)
            IDLE: begin
                if (arb_vld && !rst) begin
                    g_d = arb_idx;
                    if (s_arvalid[arb_idx]) begin
                        s_arready[arb_idx] = 1'b1;
                        op_d    = OP_RD;
                        addr_d  = s_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                        state_d = RD_ADDR;
                    end else begin
                        s_awready[arb_idx] = 1'b1;
                        s_wready[arb_idx]  = 1'b1;
                        op_d      = OP_WR;
                        addr_d    = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_d   = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                s_rvalid[g_q] = m_rvalid;
                s_rdata       = m_rdata;
                m_rready      = s_rready[g_q];
                if (resp_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            WR_ADDR: begin
                // AW and W complete independently; each valid drops once its own handshake is seen.
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if (m_awready) begin
                    aw_done_d = 1'b1;
                end
                if (m_wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s_bvalid[g_q] = m_bvalid;
                m_bready      = s_bready[g_q];
                if (resp_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state with asynchronous reset; a reset mid-transaction simply abandons it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            g_q       <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            g_q       <= g_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Captured address/data payload; only meaningful while a transaction is in flight.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: tb/tb_l3_port_arbiter.sv
// Directed bench for l3_port_arbiter with NUM_REQ=2, 32-bit address and data.
module tb_l3_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_araddr, s_awaddr, s_wdata;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_rdata;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        busy;
    logic        grant_id;

    int total = 0;
    int bad   = 0;

    l3_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] oh;
        int         e;

        rst = 1'b1;
        s_araddr = '0; s_awaddr = '0; s_wdata = '0;
        s_arvalid = 2'b01; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
        m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;

        // reset state, with a read already offered
        tick(); tick();
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        chk("rst_s_arready", 32'(s_arready), 32'd0);
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        s_arvalid = '0;
        rst = 1'b0;

        // 1: single read from requester 1
        tick();
        s_araddr[63:32] = 32'h100;
        s_arvalid = 2'b10;
        #1;
        chk("t1_arready", 32'(s_arready), 32'h2);
        tick();
        s_arvalid = '0;
        #1;
        chk("t1_m_arvalid", 32'(m_arvalid), 32'd1);
        chk("t1_m_araddr",  m_araddr,       32'h100);
        chk("t1_busy",      32'(busy),      32'd1);
        chk("t1_grant_id",  32'(grant_id),  32'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        #1;
        chk("t1_arvalid_drop", 32'(m_arvalid), 32'd0);
        chk("t1_no_rvalid",    32'(s_rvalid),  32'd0);
        tick(); tick();
        m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; s_rready = 2'b10;
        #1;
        chk("t1_s_rvalid", 32'(s_rvalid), 32'h2);
        chk("t1_s_rdata",  s_rdata,       32'hDEADBEEF);
        chk("t1_m_rready", 32'(m_rready), 32'd1);
        tick();
        m_rvalid = 1'b0; s_rready = '0;
        #1;
        chk("t1_busy_drop", 32'(busy),    32'd0);
        chk("t1_rdata_idle", s_rdata,     32'd0);

        // 2: single write from requester 0
        s_awaddr[31:0] = 32'h200; s_wdata[31:0] = 32'h12345678;
        s_awvalid = 2'b01; s_wvalid = 2'b01;
        #1;
        chk("t2_awready", 32'(s_awready), 32'h1);
        chk("t2_wready",  32'(s_wready),  32'h1);
        chk("t2_arready", 32'(s_arready), 32'h0);
        tick();
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("t2_m_awvalid", 32'(m_awvalid), 32'd1);
        chk("t2_m_wvalid",  32'(m_wvalid),  32'd1);
        chk("t2_m_awaddr",  m_awaddr,       32'h200);
        chk("t2_m_wdata",   m_wdata,        32'h12345678);
        m_awready = 1'b1; m_wready = 1'b1;
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk("t2_awvalid_drop", 32'(m_awvalid), 32'd0);
        chk("t2_wvalid_drop",  32'(m_wvalid),  32'd0);
        chk("t2_no_bvalid_pre", 32'(s_bvalid), 32'd0);
        m_bvalid = 1'b1; s_bready = 2'b01;
        #1;
        chk("t2_s_bvalid", 32'(s_bvalid), 32'h1);
        chk("t2_m_bready", 32'(m_bready), 32'd1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        #1;
        chk("t2_busy_drop", 32'(busy), 32'd0);

        // AW without W is not a request
        s_awvalid = 2'b01;
        #1;
        chk("aw_only_awready", 32'(s_awready), 32'd0);
        tick();
        chk("aw_only_busy", 32'(busy), 32'd0);
        s_awvalid = '0;

        // 3: clear pointer, then both requesters read continuously for six transactions
        rst = 1'b1;
        #1;
        rst = 1'b0;
        s_araddr = {32'hB0, 32'hA0};
        s_arvalid = 2'b11; s_rready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            e  = k % 2;
            oh = (e == 0) ? 2'b01 : 2'b10;
            #1;
            chk($sformatf("t3_arready_%0d", k), 32'(s_arready), 32'(oh));
            tick();
            chk($sformatf("t3_grant_%0d", k),  32'(grant_id), 32'(e));
            chk($sformatf("t3_araddr_%0d", k), m_araddr, (e == 0) ? 32'hA0 : 32'hB0);
            chk($sformatf("t3_hold_arready_%0d", k), 32'(s_arready), 32'd0);
            m_arready = 1'b1;
            tick();
            m_arready = 1'b0;
            m_rvalid = 1'b1; m_rdata = 32'(k + 32'h50);
            #1;
            chk($sformatf("t3_rvalid_%0d", k), 32'(s_rvalid), 32'(oh));
            chk($sformatf("t3_rdata_%0d", k),  s_rdata, 32'(k + 32'h50));
            tick();
            m_rvalid = 1'b0;
        end
        s_arvalid = '0;

        // 4: requester 0 offers AR, AW and W together; read wins first
        s_araddr[31:0] = 32'h300; s_awaddr[31:0] = 32'h400; s_wdata[31:0] = 32'hCAFE0001;
        s_arvalid = 2'b01; s_awvalid = 2'b01; s_wvalid = 2'b01;
        #1;
        chk("t4_arready", 32'(s_arready), 32'h1);
        chk("t4_awready", 32'(s_awready), 32'h0);
        chk("t4_wready",  32'(s_wready),  32'h0);
        tick();
        chk("t4_m_araddr", m_araddr, 32'h300);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0; s_arvalid = '0;
        #1;
        chk("t4_wr_awready", 32'(s_awready), 32'h1);
        chk("t4_wr_wready",  32'(s_wready),  32'h1);
        tick();
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("t4_m_awaddr", m_awaddr, 32'h400);
        chk("t4_m_wdata",  m_wdata,  32'hCAFE0001);

        // 5: AW accepted at cycle N, W accepted at N+2
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        #1;
        chk("t5_awvalid_n1", 32'(m_awvalid), 32'd0);
        chk("t5_wvalid_n1",  32'(m_wvalid),  32'd1);
        m_bvalid = 1'b1; s_bready = 2'b01;
        #1;
        chk("t5_no_bvalid_early", 32'(s_bvalid), 32'd0);
        chk("t5_no_bready_early", 32'(m_bready), 32'd0);
        m_bvalid = 1'b0;
        tick();
        chk("t5_awvalid_n2", 32'(m_awvalid), 32'd0);
        chk("t5_wvalid_n2",  32'(m_wvalid),  32'd1);
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0; s_bready = '0; m_bvalid = 1'b1;
        #1;
        chk("t5_wvalid_drop", 32'(m_wvalid), 32'd0);
        chk("t5_s_bvalid",    32'(s_bvalid), 32'h1);
        chk("t5_bready_wait", 32'(m_bready), 32'd0);
        s_bready = 2'b01;
        #1;
        chk("t5_m_bready", 32'(m_bready), 32'd1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        #1;
        chk("t5_busy_drop", 32'(busy), 32'd0);

        // 6: reset while waiting for read data
        s_araddr[63:32] = 32'h500;
        s_arvalid = 2'b10;
        tick();
        s_arvalid = '0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0; s_rready = 2'b10; s_arvalid = 2'b11;
        #1;
        chk("t6_pre_m_rready", 32'(m_rready), 32'd1);
        chk("t6_pre_grant",    32'(grant_id), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_busy",      32'(busy),      32'd0);
        chk("t6_m_rready",  32'(m_rready),  32'd0);
        chk("t6_s_arready", 32'(s_arready), 32'd0);
        chk("t6_grant_id",  32'(grant_id),  32'd0);
        chk("t6_m_arvalid", 32'(m_arvalid), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_regrant_arready", 32'(s_arready), 32'h1);
        tick();
        chk("t6_regrant_id",     32'(grant_id),  32'd0);
        chk("t6_regrant_araddr", m_araddr,       32'h300);
        chk("t6_regrant_arvalid", 32'(m_arvalid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
